// File: rtl/demux1_8_reg.sv
// demux1_8_reg: registered 1-to-8 demultiplexer with valid/ready handshakes.
// Each beat on the input stream is steered by in_sel into one of eight
// one-entry holding registers; a stalled consumer only blocks beats that
// are addressed to it.
// Optional build macro: DEMUX1_8_STALL_CNT_EN adds a 16-bit saturating
// count of input stall cycles on port stall_cnt.
module demux1_8_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready,
    output logic [8*WIDTH-1:0]   out_data
`ifdef DEMUX1_8_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int unsigned NCH   = 8;
    localparam int unsigned CNT_W = 16;

    logic [NCH-1:0]   valid_q;
    logic [WIDTH-1:0] data_q [NCH];

    logic [NCH-1:0]   valid_d;
    logic [NCH-1:0]   load_c;
    logic             accept_c;
    logic             sel_free_c;

    // Selected channel can take a beat when empty or draining this cycle.
    always_comb begin
        sel_free_c = !valid_q[in_sel] || out_ready[in_sel];
        in_ready   = rst_n && !flush && sel_free_c;
    end

    // One-hot load strobe for the channel addressed by an accepted beat.
    always_comb begin
        accept_c = in_valid && in_ready;
        load_c   = '0;
        if (accept_c) begin
            load_c = NCH'(1) << in_sel;
        end
    end

    // Next valid state: flush dominates, then load, then drain.
    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < NCH; k++) begin
            if (flush) begin
                valid_d[k] = 1'b0;
            end else if (load_c[k]) begin
                valid_d[k] = 1'b1;
            end else if (out_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    // Channel valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Channel payloads; held after a drain, replaced only on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (load_c[k]) begin
                    data_q[k] <= in_data;
                end
            end
        end
    end

    assign out_valid = valid_q;

    // Flatten channel payloads onto the output bus.
    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign out_data[g*WIDTH +: WIDTH] = data_q[g];
    end

`ifdef DEMUX1_8_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic             stall_c;

    assign stall_c = in_valid && !in_ready && !flush;

    // Saturating stall counter; cleared by reset only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (stall_c && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_demux1_8_reg.sv
// Testbench for demux1_8_reg: directed vector table, reset corner cases and
// randomized traffic checked against a per-channel beat model.
module tb_demux1_8_reg;

    localparam int unsigned WIDTH = 32;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_sel;
    logic [WIDTH-1:0]   in_data;
    logic [7:0]         out_valid;
    logic [7:0]         out_ready;
    logic [8*WIDTH-1:0] out_data;
`ifdef DEMUX1_8_STALL_CNT_EN
    logic [15:0]        stall_cnt;
`endif

    demux1_8_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX1_8_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: per channel, the list of beats currently held
    // (at most one) plus the last payload ever written.
    logic [31:0] held [8][$];
    logic [31:0] last [8];
    int          m_stall;

    typedef struct {
        logic        f;
        logic        v;
        logic [2:0]  s;
        logic [31:0] d;
        logic [7:0]  r;
        logic        e_ir;
        logic [7:0]  e_ov;
        int          e_ch;
        logic [31:0] e_data;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] slice(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    function automatic logic model_ready();
        return !flush && (held[in_sel].size() == 0 || out_ready[in_sel]);
    endfunction

    function automatic logic [7:0] model_valid();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = (held[k].size() != 0);
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            held[k].delete();
            last[k] = '0;
        end
        m_stall = 0;
    endtask

    task automatic drive(input logic f, input logic v, input logic [2:0] s,
                         input logic [31:0] d, input logic [7:0] r);
        flush = f; in_valid = v; in_sel = s; in_data = d; out_ready = r;
    endtask

    // Advance one clock, updating the model from the inputs present at the edge.
    task automatic tick();
        logic acc;
        acc = in_valid && model_ready();
        if (in_valid && !model_ready() && !flush && m_stall < 16'hFFFF) m_stall++;
        if (flush) begin
            for (int k = 0; k < 8; k++) held[k].delete();
        end else begin
            for (int k = 0; k < 8; k++)
                if (out_ready[k] && held[k].size() != 0) void'(held[k].pop_front());
            if (acc) begin
                held[in_sel].push_back(in_data);
                last[in_sel] = in_data;
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [17];

    initial begin
        // flush, valid, sel, data, ready | in_ready, out_valid, chan, data
        vecs[0]  = '{1'b0, 1'b1, 3'd5, 32'h12345678, 8'hFF, 1'b1, 8'h20, 5, 32'h12345678};
        vecs[1]  = '{1'b0, 1'b0, 3'd5, 32'h0,        8'hFF, 1'b1, 8'h00, 5, 32'h12345678};
        vecs[2]  = '{1'b0, 1'b1, 3'd2, 32'hAAAA0002, 8'h00, 1'b1, 8'h04, 2, 32'hAAAA0002};
        vecs[3]  = '{1'b0, 1'b1, 3'd2, 32'hBBBB0002, 8'h00, 1'b0, 8'h04, 2, 32'hAAAA0002};
        vecs[4]  = '{1'b0, 1'b1, 3'd6, 32'h66666666, 8'h00, 1'b1, 8'h44, 6, 32'h66666666};
        vecs[5]  = '{1'b0, 1'b1, 3'd2, 32'hBBBB0002, 8'h04, 1'b1, 8'h44, 2, 32'hBBBB0002};
        vecs[6]  = '{1'b0, 1'b0, 3'd0, 32'h0,        8'hFF, 1'b1, 8'h00, 6, 32'h66666666};
        vecs[7]  = '{1'b0, 1'b1, 3'd0, 32'h1,        8'h01, 1'b1, 8'h01, 0, 32'h1};
        vecs[8]  = '{1'b0, 1'b1, 3'd0, 32'h2,        8'h01, 1'b1, 8'h01, 0, 32'h2};
        vecs[9]  = '{1'b0, 1'b1, 3'd0, 32'h3,        8'h01, 1'b1, 8'h01, 0, 32'h3};
        vecs[10] = '{1'b0, 1'b1, 3'd0, 32'h4,        8'h01, 1'b1, 8'h01, 0, 32'h4};
        vecs[11] = '{1'b0, 1'b0, 3'd0, 32'h0,        8'h01, 1'b1, 8'h00, 0, 32'h4};
        vecs[12] = '{1'b0, 1'b1, 3'd1, 32'h11111111, 8'h00, 1'b1, 8'h02, 1, 32'h11111111};
        vecs[13] = '{1'b0, 1'b1, 3'd4, 32'h44444444, 8'h00, 1'b1, 8'h12, 4, 32'h44444444};
        vecs[14] = '{1'b0, 1'b1, 3'd7, 32'h77777777, 8'h00, 1'b1, 8'h92, 7, 32'h77777777};
        vecs[15] = '{1'b1, 1'b1, 3'd1, 32'hFFFF0001, 8'h00, 1'b0, 8'h00, 1, 32'h11111111};
        vecs[16] = '{1'b0, 1'b0, 3'd1, 32'h0,        8'h00, 1'b1, 8'h00, 1, 32'h11111111};

        // Power-on reset with a pending input beat.
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 3'd0, 32'hCAFE0000, 8'hFF);
        model_reset();
        #1;
        check("por_out_valid", 64'(out_valid), 64'h0);
        check("por_in_ready", 64'(in_ready), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        check("por_held_in_ready", 64'(in_ready), 64'h0);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 8'h00);
        rst_n = 1'b1;
        #1;

        // Directed vector table.
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].f, vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].r);
            #1;
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
            tick();
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            check($sformatf("vec%0d_data", i), 64'(slice(vecs[i].e_ch)), 64'(vecs[i].e_data));
        end

        // Reset asserted between edges while channel 3 holds a beat.
        drive(1'b0, 1'b1, 3'd3, 32'hDEADBEEF, 8'h00);
        tick();
        check("rst_pre_valid", 64'(out_valid), 64'h08);
        check("rst_pre_data", 64'(slice(3)), 64'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'h0);
        check("rst_async_data_nz", 64'(|out_data), 64'h0);
        check("rst_async_in_ready", 64'(in_ready), 64'h0);
        @(posedge clk);
        #1;
        check("rst_hold_in_ready", 64'(in_ready), 64'h0);
        check("rst_hold_valid", 64'(out_valid), 64'h0);
        model_reset();
        rst_n = 1'b1;
        #1;
        check("rst_release_in_ready", 64'(in_ready), 64'h1);
        tick();
        check("rst_first_accept_valid", 64'(out_valid), 64'h08);
        check("rst_first_accept_data", 64'(slice(3)), 64'hDEADBEEF);

`ifdef DEMUX1_8_STALL_CNT_EN
        // Block channel 0 for ten cycles, then flush; count must not move on flush.
        drive(1'b0, 1'b1, 3'd0, 32'h0000A000, 8'h00);
        tick();
        check("stall_before", 64'(stall_cnt), 64'h0);
        for (int i = 0; i < 10; i++) tick();
        check("stall_ten", 64'(stall_cnt), 64'd10);
        drive(1'b1, 1'b1, 3'd0, 32'h0000A001, 8'h00);
        tick();
        check("stall_flush_hold", 64'(stall_cnt), 64'd10);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                  3'($urandom_range(0, 7)), $urandom, 8'($urandom));
            #1;
            check("rnd_in_ready", 64'(in_ready), 64'(model_ready()));
            tick();
            check("rnd_out_valid", 64'(out_valid), 64'(model_valid()));
            for (int k = 0; k < 8; k++) begin
                if (slice(k) !== last[k])
                    check($sformatf("rnd_data_ch%0d", k), 64'(slice(k)), 64'(last[k]));
            end
`ifdef DEMUX1_8_STALL_CNT_EN
            check("rnd_stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
        end
        // Payload comparison over all channels once at the end of random traffic.
        for (int k = 0; k < 8; k++)
            check($sformatf("rnd_final_ch%0d", k), 64'(slice(k)), 64'(last[k]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
